// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage and IF/ID pipeline register.
// Holds the fetch PC and runs a variable-latency req/ack handshake to
// instruction memory. Fetched instructions are presented to decode with
// their PC and opcode. Branch, flush and stall come from decode.
module fetch_unit #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_stallD,
    input  logic               i_branchD,
    input  logic               i_flushD,
    input  logic [PC_W-1:0]    i_branch_target,
    output logic               o_imem_req,
    output logic [PC_W-1:0]    o_imem_addr,
    input  logic               i_imem_ack,
    input  logic [INSTR_W-1:0] i_imem_data,
    output logic [INSTR_W-1:0] o_instrD,
    output logic [3:0]         o_opcodeD,
    output logic [PC_W-1:0]    o_pcD,
    output logic               o_validD
);

    localparam logic [PC_W-1:0] RESET_ADDR = PC_W'(RESET_PC);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } state_t;

    state_t             state;
    logic [PC_W-1:0]    pcF;
    logic [PC_W-1:0]    tgt;
    logic               kill;
    logic [INSTR_W-1:0] holdInstr;
    logic [PC_W-1:0]    holdPc;

    logic fetchAck;
    logic loadFetch;
    logic loadHold;

    // Decode which source, if any, feeds the IF/ID register this cycle
    always_comb begin
        fetchAck  = (state == FETCH) && i_imem_ack;
        loadFetch = fetchAck && !i_branchD && !kill && !i_stallD;
        loadHold  = (state == HOLD) && !i_branchD && !i_stallD;
    end

    assign o_imem_req  = (state == FETCH);
    assign o_imem_addr = pcF;
    assign o_opcodeD   = o_instrD[INSTR_W-1 -: 4];

    // Fetch sequencer: PC, pending-redirect (kill/tgt) and stall hold buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pcF       <= RESET_ADDR;
            tgt       <= '0;
            kill      <= 1'b0;
            holdInstr <= '0;
            holdPc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_branchD) begin
                        pcF <= i_branch_target;
                    end
                    state <= FETCH;
                end
                FETCH: begin
                    if (i_imem_ack) begin
                        if (i_branchD) begin
                            // newest branch overrides any pending redirect
                            pcF  <= i_branch_target;
                            kill <= 1'b0;
                        end else if (kill) begin
                            pcF  <= tgt;
                            kill <= 1'b0;
                        end else begin
                            pcF <= pcF + PC_W'(1);
                            if (i_stallD) begin
                                holdInstr <= i_imem_data;
                                holdPc    <= pcF;
                                state     <= HOLD;
                            end
                        end
                    end else if (i_branchD) begin
                        // address must stay put until ack; remember redirect
                        tgt  <= i_branch_target;
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    if (i_branchD) begin
                        pcF   <= i_branch_target;
                        state <= FETCH;
                    end else if (!i_stallD) begin
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // IF/ID register: flush > stall > load > bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_instrD <= '0;
            o_pcD    <= '0;
            o_validD <= 1'b0;
        end else if (i_flushD) begin
            o_instrD <= '0;
            o_pcD    <= '0;
            o_validD <= 1'b0;
        end else if (i_stallD) begin
            o_instrD <= o_instrD;
        end else if (loadFetch) begin
            o_instrD <= i_imem_data;
            o_pcD    <= pcF;
            o_validD <= 1'b1;
        end else if (loadHold) begin
            o_instrD <= holdInstr;
            o_pcD    <= holdPc;
            o_validD <= 1'b1;
        end else begin
            o_instrD <= '0;
            o_validD <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven streaming runs with a scoreboard, plus
// hand-written sequences for stall, redirect, flush, wrap and reset.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        i_stallD;
    logic        i_branchD;
    logic        i_flushD;
    logic [7:0]  i_branch_target;
    logic        o_imem_req;
    logic [7:0]  o_imem_addr;
    logic        i_imem_ack;
    logic [15:0] i_imem_data;
    logic [15:0] o_instrD;
    logic [3:0]  o_opcodeD;
    logic [7:0]  o_pcD;
    logic        o_validD;

    fetch_unit #(
        .PC_W    (8),
        .INSTR_W (16),
        .RESET_PC(0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_stallD       (i_stallD),
        .i_branchD      (i_branchD),
        .i_flushD       (i_flushD),
        .i_branch_target(i_branch_target),
        .o_imem_req     (o_imem_req),
        .o_imem_addr    (o_imem_addr),
        .i_imem_ack     (i_imem_ack),
        .i_imem_data    (i_imem_data),
        .o_instrD       (o_instrD),
        .o_opcodeD      (o_opcodeD),
        .o_pcD          (o_pcD),
        .o_validD       (o_validD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: memory[a] = 16'h1000 + a
    logic        memAuto;
    logic        manAck;
    logic        autoAck;
    int unsigned ackDelay;
    int unsigned cnt;
    logic        prevReq;
    logic        prevAck;

    assign i_imem_data = 16'h1000 + {8'h00, o_imem_addr};
    assign i_imem_ack  = memAuto ? autoAck : manAck;

    // auto responder: ack after ackDelay wait cycles of a held request
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= 0;
            autoAck <= 1'b0;
            prevReq <= 1'b0;
            prevAck <= 1'b0;
        end else begin
            int unsigned cntNow;
            cntNow = (prevReq && prevAck) ? 0 : (prevReq ? cnt + 1 : cnt);
            cnt     <= cntNow;
            autoAck <= o_imem_req && (cntNow >= ackDelay);
            prevReq <= o_imem_req;
            prevAck <= o_imem_req && (cntNow >= ackDelay);
        end
    end

    int checks;
    int errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic doReset(input logic autoMode, input int unsigned dly);
        reset           = 1'b1;
        i_stallD        = 1'b0;
        i_branchD       = 1'b0;
        i_flushD        = 1'b0;
        i_branch_target = 8'h00;
        memAuto         = autoMode;
        manAck          = 1'b0;
        ackDelay        = dly;
        repeat (2) @(negedge clk);
        check("rst_req",    32'(o_imem_req),  32'd0);
        check("rst_addr",   32'(o_imem_addr), 32'd0);
        check("rst_instr",  32'(o_instrD),    32'd0);
        check("rst_opcode", 32'(o_opcodeD),   32'd0);
        check("rst_pc",     32'(o_pcD),       32'd0);
        check("rst_valid",  32'(o_validD),    32'd0);
        reset = 1'b0;
        check("idle_req", 32'(o_imem_req), 32'd0);
    endtask

    task automatic waitAddr(input logic [7:0] a);
        int n;
        n = 0;
        while (!(o_imem_req && o_imem_addr == a) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wait_addr", 32'(o_imem_addr), 32'(a));
    endtask

    typedef struct {
        int unsigned delay;
        int unsigned count;
        int unsigned firstNeg;
        int unsigned period;
    } streamVec_t;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] instr;
    } exp_t;

    streamVec_t vecs[3];
    exp_t       sbQ[$];

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        vecs[0] = '{delay: 0, count: 12, firstNeg: 2, period: 1};
        vecs[1] = '{delay: 3, count: 6,  firstNeg: 5, period: 4};
        vecs[2] = '{delay: 1, count: 8,  firstNeg: 3, period: 2};

        // streaming runs from reset
        for (int v = 0; v < 3; v++) begin
            int unsigned popped;
            int unsigned negIdx;
            int unsigned budget;
            doReset(1'b1, vecs[v].delay);
            for (int k = 0; k < int'(vecs[v].count); k++)
                sbQ.push_back('{pc: 8'(k), instr: 16'(32'h1000 + k)});
            popped = 0;
            negIdx = 0;
            budget = vecs[v].firstNeg + vecs[v].count * vecs[v].period + 10;
            while (popped < vecs[v].count && negIdx < budget) begin
                @(negedge clk);
                negIdx++;
                if (o_validD) begin
                    if (sbQ.size() == 0) begin
                        check("sb_extra", 32'(o_pcD), 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = sbQ.pop_front();
                        check("sb_pc",     32'(o_pcD),     32'(e.pc));
                        check("sb_instr",  32'(o_instrD),  32'(e.instr));
                        check("sb_opcode", 32'(o_opcodeD), 32'h1);
                        check("sb_cycle",  negIdx, vecs[v].firstNeg + popped * vecs[v].period);
                        popped++;
                    end
                end
                if (o_imem_req) check("sb_addr", 32'(o_imem_addr), popped);
            end
            check("sb_done", popped, vecs[v].count);
            sbQ.delete();
        end

        // stall two cycles while addr 5 is acked
        doReset(1'b1, 0);
        waitAddr(8'h05);
        check("st_pre_pc", 32'(o_pcD), 32'h04);
        i_stallD = 1'b1;
        @(negedge clk);
        check("st1_req",   32'(o_imem_req), 32'd0);
        check("st1_pc",    32'(o_pcD),      32'h04);
        check("st1_instr", 32'(o_instrD),   32'h1004);
        check("st1_valid", 32'(o_validD),   32'd1);
        @(negedge clk);
        check("st2_req",   32'(o_imem_req), 32'd0);
        check("st2_pc",    32'(o_pcD),      32'h04);
        i_stallD = 1'b0;
        @(negedge clk);
        check("st_rel_pc",    32'(o_pcD),       32'h05);
        check("st_rel_instr", 32'(o_instrD),    32'h1005);
        check("st_rel_valid", 32'(o_validD),    32'd1);
        check("st_rel_addr",  32'(o_imem_addr), 32'h06);
        @(negedge clk);
        check("st_next_pc", 32'(o_pcD), 32'h06);

        // branch while request to 7 waits: ack for 7 dropped
        doReset(1'b0, 0);
        manAck = 1'b1;
        waitAddr(8'h07);
        manAck = 1'b0;
        @(negedge clk);
        check("kb_wait_addr", 32'(o_imem_addr), 32'h07);
        i_branchD       = 1'b1;
        i_branch_target = 8'h40;
        @(negedge clk);
        i_branchD = 1'b0;
        check("kb_hold_addr", 32'(o_imem_addr), 32'h07);
        check("kb_valid0",    32'(o_validD),    32'd0);
        manAck = 1'b1;
        @(negedge clk);
        check("kb_drop_valid", 32'(o_validD),    32'd0);
        check("kb_new_addr",   32'(o_imem_addr), 32'h40);
        @(negedge clk);
        check("kb_tgt_pc",    32'(o_pcD),    32'h40);
        check("kb_tgt_instr", 32'(o_instrD), 32'h1040);
        check("kb_tgt_valid", 32'(o_validD), 32'd1);

        // branch + ack together while kill pending: newest target wins
        manAck = 1'b0;
        @(negedge clk);
        i_branchD       = 1'b1;
        i_branch_target = 8'h20;
        @(negedge clk);
        i_branch_target = 8'h30;
        manAck          = 1'b1;
        @(negedge clk);
        i_branchD = 1'b0;
        check("bk_addr",  32'(o_imem_addr), 32'h30);
        check("bk_valid", 32'(o_validD),    32'd0);
        @(negedge clk);
        check("bk_pc",    32'(o_pcD),    32'h30);
        check("bk_valid1", 32'(o_validD), 32'd1);

        // flush with stall clears IF/ID; stalled fetch then delivered
        i_flushD = 1'b1;
        i_stallD = 1'b1;
        @(negedge clk);
        check("fl_valid",  32'(o_validD),  32'd0);
        check("fl_instr",  32'(o_instrD),  32'd0);
        check("fl_opcode", 32'(o_opcodeD), 32'd0);
        check("fl_pc",     32'(o_pcD),     32'd0);
        i_flushD = 1'b0;
        i_stallD = 1'b0;
        @(negedge clk);
        check("fl_after_pc",    32'(o_pcD),    32'h31);
        check("fl_after_valid", 32'(o_validD), 32'd1);

        // PC wrap from 8'hFF to 8'h00
        i_branchD       = 1'b1;
        i_branch_target = 8'hFE;
        @(negedge clk);
        i_branchD = 1'b0;
        check("wr_addr_fe", 32'(o_imem_addr), 32'hFE);
        @(negedge clk);
        check("wr_addr_ff", 32'(o_imem_addr), 32'hFF);
        check("wr_pc_fe",   32'(o_pcD),       32'hFE);
        @(negedge clk);
        check("wr_addr_00", 32'(o_imem_addr), 32'h00);
        check("wr_pc_ff",   32'(o_pcD),       32'hFF);
        check("wr_instr_ff", 32'(o_instrD),   32'h10FF);
        @(negedge clk);
        check("wr_pc_00",    32'(o_pcD),    32'h00);
        check("wr_valid_00", 32'(o_validD), 32'd1);

        // asynchronous reset in the middle of a waiting request
        manAck = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("mr_req",    32'(o_imem_req),  32'd0);
        check("mr_addr",   32'(o_imem_addr), 32'd0);
        check("mr_instr",  32'(o_instrD),    32'd0);
        check("mr_opcode", 32'(o_opcodeD),   32'd0);
        check("mr_pc",     32'(o_pcD),       32'd0);
        check("mr_valid",  32'(o_validD),    32'd0);
        manAck = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mr_idle_req", 32'(o_imem_req), 32'd0);
        @(negedge clk);
        check("mr_req1",   32'(o_imem_req),  32'd1);
        check("mr_addr0",  32'(o_imem_addr), 32'd0);
        check("mr_valid0", 32'(o_validD),    32'd0);
        @(negedge clk);
        check("mr_first_pc",    32'(o_pcD),    32'd0);
        check("mr_first_valid", 32'(o_validD), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
